// File: rtl/issue_scoreboard_pkg.sv
// Shared widths, latency constants and lane field packing for the issue scoreboard.
// Lane i of any packed per-lane bus occupies bits [i*W +: W], so lane 0 sits in the LSBs.
package issue_scoreboard_pkg;

  localparam int REG_W_DEF = 5;
  localparam int LAT_W_DEF = 3;
  localparam int LAT_ALU   = 1;
  localparam int LAT_LOAD  = 2;

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue bundle request/grant bundle between the decode stage and the scoreboard.
// Grant and stall are combinational answers to the request in the same cycle.
interface issue_scoreboard_if
  import issue_scoreboard_pkg::*;
#(
  parameter int LANES = 2,
  parameter int REG_W = REG_W_DEF,
  parameter int LAT_W = LAT_W_DEF
);

  logic [LANES-1:0]       iss_valid;
  logic [LANES*REG_W-1:0] iss_rs;
  logic [LANES*REG_W-1:0] iss_rt;
  logic [LANES-1:0]       iss_use_rt;
  logic [LANES-1:0]       iss_wr;
  logic [LANES*REG_W-1:0] iss_dst;
  logic [LANES*LAT_W-1:0] iss_lat;
  logic                   flush;
  logic [LANES-1:0]       grant;
  logic                   stall;

  modport master (
    output iss_valid, iss_rs, iss_rt, iss_use_rt, iss_wr, iss_dst, iss_lat, flush,
    input  grant, stall
  );

  modport slave (
    input  iss_valid, iss_rs, iss_rt, iss_use_rt, iss_wr, iss_dst, iss_lat, flush,
    output grant, stall
  );

endinterface

// File: rtl/issue_scoreboard_sb_entry.sv
// Per-register result-pending down-counter: reload on issue, else count down to zero.
// One-cycle update on the clock edge; no backpressure, reset clears it asynchronously.
module sb_entry
  import issue_scoreboard_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order multi-lane issue scoreboard: RAW/WAW/intra-bundle hazard check with per-register latency counters.
// Grant/stall are zero-latency combinational; a blocked lane holds back every younger lane.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int LANES = 2,
  parameter int NREG  = 32,
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  issue_scoreboard_if.slave   bus,
  output logic [NREG-1:0]     busy_vec,
  output logic [15:0]         stall_cnt
);

  localparam int REG_W = $clog2(NREG);

  logic [NREG-1:0][LAT_W-1:0] cnt;
  logic [NREG-1:1]            ld;
  logic [NREG-1:1][LAT_W-1:0] ld_val;

  logic [REG_W-1:0] rs  [LANES];
  logic [REG_W-1:0] rt  [LANES];
  logic [REG_W-1:0] dst [LANES];
  logic [LAT_W-1:0] eff [LANES];

  logic [LANES-1:0] raw_blk;
  logic [LANES-1:0] intra_blk;
  logic [LANES-1:0] waw_blk;
  logic [LANES-1:0] grant_c;
  logic             in_order;
  logic             stall_c;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rs[i]  = bus.iss_rs[lane_lsb(i, REG_W) +: REG_W];
      rt[i]  = bus.iss_rt[lane_lsb(i, REG_W) +: REG_W];
      dst[i] = bus.iss_dst[lane_lsb(i, REG_W) +: REG_W];
      // A zero latency field still occupies one cycle before forwarding.
      eff[i] = (bus.iss_lat[lane_lsb(i, LAT_W) +: LAT_W] == '0)
               ? LAT_W'(1) : bus.iss_lat[lane_lsb(i, LAT_W) +: LAT_W];
    end
  end

  always_comb begin
    raw_blk   = '0;
    intra_blk = '0;
    waw_blk   = '0;
    grant_c   = '0;
    in_order  = rst && !bus.flush;
    for (int i = 0; i < LANES; i++) begin
      raw_blk[i] = (cnt[rs[i]] != '0) || (bus.iss_use_rt[i] && (cnt[rt[i]] != '0));
      for (int j = 0; j < LANES; j++) begin
        if (j < i && bus.iss_valid[j] && bus.iss_wr[j] && dst[j] != '0 &&
            (dst[j] == rs[i] || (bus.iss_use_rt[i] && dst[j] == rt[i]))) begin
          intra_blk[i] = 1'b1;
        end
      end
      waw_blk[i] = bus.iss_wr[i] && (dst[i] != '0) && (cnt[dst[i]] >= eff[i]);
      grant_c[i] = in_order && bus.iss_valid[i] && !(raw_blk[i] || intra_blk[i] || waw_blk[i]);
      // Once an older valid lane is held, nothing younger may issue past it.
      if (bus.iss_valid[i] && !grant_c[i]) begin
        in_order = 1'b0;
      end
    end
  end

  assign stall_c   = rst && !bus.flush && |(bus.iss_valid & ~grant_c);
  assign bus.grant = grant_c;
  assign bus.stall = stall_c;

  // Ascending lane scan lets the youngest writer of a register win the reload.
  always_comb begin
    ld     = '0;
    ld_val = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int i = 0; i < LANES; i++) begin
        if (grant_c[i] && bus.iss_wr[i] && dst[i] == REG_W'(r)) begin
          ld[r]     = 1'b1;
          ld_val[r] = eff[i] - LAT_W'(1);
        end
      end
    end
  end

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .load     (ld[r]),
      .load_val (ld_val[r]),
      .cnt      (cnt[r])
    );
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_c && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: table of per-cycle requests with expected grant/stall/busy/stall_cnt,
// routed through an expectation queue, plus a hand-written asynchronous reset sequence.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic clk;
  logic rst;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  issue_scoreboard_if #(.LANES(2), .REG_W(5), .LAT_W(3)) sbif ();

  issue_scoreboard #(.LANES(2), .NREG(32), .LAT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (sbif),
    .busy_vec  (busy_vec),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  rs0, rt0, dst0, rs1, rt1, dst1;
    logic        ut0, wr0, ut1, wr1;
    logic [2:0]  lat0, lat1;
    logic        fl;
    logic [1:0]  g;
    logic        st;
    logic [31:0] busy;
    logic [15:0] scnt;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];
  vec_t exp_q [$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(input int va,
                              input int rs0, input int rt0, input int ut0, input int wr0,
                              input int dst0, input int lat0,
                              input int rs1, input int rt1, input int ut1, input int wr1,
                              input int dst1, input int lat1,
                              input int fl, input int g, input int st,
                              input logic [31:0] busy, input int scnt);
    vec_t v;
    v.valid = 2'(va);
    v.rs0 = 5'(rs0); v.rt0 = 5'(rt0); v.ut0 = 1'(ut0); v.wr0 = 1'(wr0);
    v.dst0 = 5'(dst0); v.lat0 = 3'(lat0);
    v.rs1 = 5'(rs1); v.rt1 = 5'(rt1); v.ut1 = 1'(ut1); v.wr1 = 1'(wr1);
    v.dst1 = 5'(dst1); v.lat1 = 3'(lat1);
    v.fl = 1'(fl); v.g = 2'(g); v.st = 1'(st); v.busy = busy; v.scnt = 16'(scnt);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    sbif.iss_valid  = v.valid;
    sbif.iss_rs     = {v.rs1, v.rs0};
    sbif.iss_rt     = {v.rt1, v.rt0};
    sbif.iss_use_rt = {v.ut1, v.ut0};
    sbif.iss_wr     = {v.wr1, v.wr0};
    sbif.iss_dst    = {v.dst1, v.dst0};
    sbif.iss_lat    = {v.lat1, v.lat0};
    sbif.flush      = v.fl;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    apply(v);
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL r%0d queue: got empty want entry", idx);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("r%0d grant", idx), 32'(sbif.grant), 32'(e.g));
      check($sformatf("r%0d stall", idx), 32'(sbif.stall), 32'(e.st));
      check($sformatf("r%0d busy", idx), busy_vec, e.busy);
      check($sformatf("r%0d stall_cnt", idx), 32'(stall_cnt), 32'(e.scnt));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // load, dependent ALU op stalls one cycle
    tbl[0]  = mk(0, 0,0,0,0,0,0, 0,0,0,0,0,0, 0, 0,0, 32'h0, 0);
    tbl[1]  = mk(1, 1,0,0,1,8,LAT_LOAD, 0,0,0,0,0,0, 0, 1,0, 32'h0, 0);
    tbl[2]  = mk(1, 8,1,1,1,9,LAT_ALU, 0,0,0,0,0,0, 0, 0,1, 32'h100, 0);
    tbl[3]  = mk(1, 8,1,1,1,9,LAT_ALU, 0,0,0,0,0,0, 0, 1,0, 32'h0, 1);
    // intra-bundle dependency
    tbl[4]  = mk(3, 1,2,1,1,5,1, 5,3,1,1,6,1, 0, 1,1, 32'h0, 1);
    tbl[5]  = mk(2, 0,0,0,0,0,0, 5,3,1,1,6,1, 0, 2,0, 32'h0, 2);
    // no overtake of a RAW-blocked older lane
    tbl[6]  = mk(1, 1,0,0,1,10,3, 0,0,0,0,0,0, 0, 1,0, 32'h0, 2);
    tbl[7]  = mk(3, 10,1,1,1,11,1, 2,3,1,1,12,1, 0, 0,1, 32'h400, 2);
    tbl[8]  = mk(3, 10,1,1,1,11,1, 2,3,1,1,12,1, 0, 0,1, 32'h400, 3);
    tbl[9]  = mk(3, 10,1,1,1,11,1, 2,3,1,1,12,1, 0, 3,0, 32'h0, 4);
    // same-cycle double write, higher lane wins; $0 never busy
    tbl[10] = mk(3, 1,0,0,1,7,1, 2,0,0,1,7,3, 0, 3,0, 32'h0, 4);
    tbl[11] = mk(0, 0,0,0,0,0,0, 0,0,0,0,0,0, 0, 0,0, 32'h80, 4);
    tbl[12] = mk(0, 0,0,0,0,0,0, 0,0,0,0,0,0, 0, 0,0, 32'h80, 4);
    tbl[13] = mk(1, 1,0,0,1,0,3, 0,0,0,0,0,0, 0, 1,0, 32'h0, 4);
    tbl[14] = mk(0, 0,0,0,0,0,0, 0,0,0,0,0,0, 0, 0,0, 32'h0, 4);
    // WAW: short op waits until the long write drains below its latency
    tbl[15] = mk(1, 1,0,0,1,13,3, 0,0,0,0,0,0, 0, 1,0, 32'h0, 4);
    tbl[16] = mk(1, 1,2,1,1,13,1, 0,0,0,0,0,0, 0, 0,1, 32'h2000, 4);
    tbl[17] = mk(1, 1,2,1,1,13,1, 0,0,0,0,0,0, 0, 0,1, 32'h2000, 5);
    tbl[18] = mk(1, 1,2,1,1,13,1, 0,0,0,0,0,0, 0, 1,0, 32'h0, 6);
    // flush: nothing issues, pending load still drains
    tbl[19] = mk(1, 1,0,0,1,14,2, 0,0,0,0,0,0, 0, 1,0, 32'h0, 6);
    tbl[20] = mk(3, 1,0,0,1,15,3, 2,0,0,1,16,3, 1, 0,0, 32'h4000, 6);
    tbl[21] = mk(0, 0,0,0,0,0,0, 0,0,0,0,0,0, 0, 0,0, 32'h0, 6);
    // latency 0 behaves as 1
    tbl[22] = mk(1, 1,0,0,1,17,0, 0,0,0,0,0,0, 0, 1,0, 32'h0, 6);
    tbl[23] = mk(1, 17,0,0,1,18,1, 0,0,0,0,0,0, 0, 1,0, 32'h0, 6);
    tbl[24] = mk(1, 1,0,0,1,4,4, 0,0,0,0,0,0, 0, 1,0, 32'h0, 6);

    rst = 1'b0;
    apply(mk(3, 1,2,1,1,3,1, 4,5,1,1,6,1, 0, 0,0, 32'h0, 0));
    #3;
    check("reset grant", 32'(sbif.grant), 32'h0);
    check("reset stall", 32'(sbif.stall), 32'h0);
    check("reset busy", busy_vec, 32'h0);
    check("reset stall_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < NV; k++) begin
      run_vec(k, tbl[k]);
    end

    // cnt[4]=3 now; request a reader of $4 so the bundle is stalled, then reset mid-cycle
    apply(mk(1, 4,1,1,1,5,1, 0,0,0,0,0,0, 0, 0,0, 32'h0, 0));
    #1;
    check("pre-rst grant", 32'(sbif.grant), 32'h0);
    check("pre-rst stall", 32'(sbif.stall), 32'h1);
    check("pre-rst busy", busy_vec, 32'h10);
    check("pre-rst stall_cnt", 32'(stall_cnt), 32'd6);
    rst = 1'b0;
    #1;
    check("async rst busy", busy_vec, 32'h0);
    check("async rst stall_cnt", 32'(stall_cnt), 32'h0);
    check("async rst grant", 32'(sbif.grant), 32'h0);
    check("async rst stall", 32'(sbif.stall), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post-rst grant", 32'(sbif.grant), 32'h1);
    check("post-rst stall", 32'(sbif.stall), 32'h0);
    check("post-rst busy", busy_vec, 32'h0);
    @(posedge clk);
    #1;
    apply(mk(0, 0,0,0,0,0,0, 0,0,0,0,0,0, 0, 0,0, 32'h0, 0));
    check("post-rst stall_cnt", 32'(stall_cnt), 32'h0);
    check("post-rst drain busy", busy_vec, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
